// File: rtl/div_pkg.sv
// Shared types and constants for the divider writeback stage.
package div_pkg;

  localparam int XLEN = 64;
  localparam int RDW  = 5;

  localparam logic OP_DIV = 1'b0;
  localparam logic OP_REM = 1'b1;

  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [RDW-1:0]  rd;
    logic            exc;
  } div_entry_t;

endpackage

// File: rtl/div_fixup.sv
// Opcode select plus divide-by-zero / signed-overflow substitution (combinational).
// With DIV_TRAP_EN defined, divide-by-zero yields data 0 and exc 1 instead of substitution.
module div_fixup
  import div_pkg::*;
(
  input  logic            i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [XLEN-1:0] i_q,
  input  logic [XLEN-1:0] i_r,
  input  logic            i_dz,
  output logic [XLEN-1:0] o_data,
  output logic            o_exc
);

  logic w_ovf;

  assign w_ovf = (i_a == INT_MIN) && (i_b == ALL_ONES);

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    o_data = (i_op == OP_REM) ? i_r : i_q;
    o_exc  = 1'b0;
    if (i_dz) begin
`ifdef DIV_TRAP_EN
      o_data = '0;
      o_exc  = 1'b1;
`else
      o_data = (i_op == OP_REM) ? i_a : ALL_ONES;
`endif
    end else if (w_ovf) begin
      o_data = (i_op == OP_REM) ? '0 : INT_MIN;
    end
  end

endmodule

// File: rtl/div_wb_stage.sv
// Captures divider results, applies fix-ups and queues them toward writeback.
// Optional macro DIV_TRAP_EN turns divide-by-zero into a trapping entry (out_exc).
module div_wb_stage #(
  parameter int DEPTH = 2,
  parameter int XLEN  = div_pkg::XLEN,
  parameter int RDW   = div_pkg::RDW,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [XLEN-1:0] in_q,
  input  logic [XLEN-1:0] in_r,
  input  logic            in_dz,
  input  logic [RDW-1:0]  in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [RDW-1:0]  out_rd,
  output logic            out_exc,
  output logic [CNTW-1:0] dz_count
);

  import div_pkg::*;

  localparam int            PW       = $clog2(DEPTH);
  localparam int            CW       = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  div_entry_t      r_mem [DEPTH];
  div_entry_t      r_head;
  logic [CNTW-1:0] r_dz_count;

  logic [XLEN-1:0] w_fix_data;
  logic            w_fix_exc;
  div_entry_t      w_wr_entry;
  logic            w_push;
  logic            w_pop;
  logic [PW-1:0]   w_rptr_nxt;

  div_fixup u_fixup (
    .i_op   (in_op),
    .i_a    (in_a),
    .i_b    (in_b),
    .i_q    (in_q),
    .i_r    (in_r),
    .i_dz   (in_dz),
    .o_data (w_fix_data),
    .o_exc  (w_fix_exc)
  );

  assign w_wr_entry = '{data: w_fix_data, rd: in_rd, exc: w_fix_exc};

  assign in_ready   = (r_count != FULL_CNT);
  assign out_valid  = (r_count != '0);
  assign w_push     = in_valid && in_ready && !flush;
  assign w_pop      = out_valid && out_ready;
  assign w_rptr_nxt = r_rptr + PW'(1);

  assign out_data = r_head.data;
  assign out_rd   = r_head.rd;
  assign out_exc  = r_head.exc;
  assign dz_count = r_dz_count;

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= w_rptr_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head register mirrors mem[rptr]; when the next head is being written this cycle, bypass the write data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
    end else if (!flush) begin
      if (w_push && ((r_count == '0) || (w_pop && r_count == ONE_CNT)))
        r_head <= w_wr_entry;
      else if (w_pop && (r_count > ONE_CNT))
        r_head <= r_mem[w_rptr_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_dz_count <= '0;
    else if (w_push && in_dz && (r_dz_count != {CNTW{1'b1}}))
      r_dz_count <= r_dz_count + CNTW'(1);
  end

  // NOTE: storage has no reset; the pointers and occupancy alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_wr_entry;
  end

endmodule
